// File: rtl/binary_ca_frame_reader.sv
// binary_ca_frame_reader
//   Read-out end of the binary cellular automaton grid. A start request snapshots
//   the flat Width*Height state vector. The snapshot is then streamed one row per
//   beat over a valid/ready interface. The live-cell population of the frame is
//   reported when the frame ends. The CA core keeps running while a frame drains,
//   because only the snapshot is streamed.
//
// Ports
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-low reset
//   start        in   frame request, level-sampled in IDLE only
//   state        in   CA grid, cell (l,c) = state[l*Width+c]
//   busy         out  high from the capture cycle until DONE completes
//   out_valid    out  beat valid
//   out_ready    in   sink accepts the beat when out_valid && out_ready
//   out_data     out  snapshot row out_row, bit c = column c
//   out_row      out  row index of the current beat
//   out_first    out  high with the row 0 beat
//   out_last     out  high with the row Height-1 beat
//   live_count   out  live cells in the last completed frame
//   count_valid  out  one-cycle pulse when live_count updates
module binary_ca_frame_reader #(
  parameter  int Width     = 8,
  parameter  int Height    = 8,
  localparam int RowBits   = (Height > 1) ? $clog2(Height) : 1,
  localparam int CountBits = $clog2(Width * Height + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [Width*Height-1:0]   state,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Width-1:0]          out_data,
  output logic [RowBits-1:0]        out_row,
  output logic                      out_first,
  output logic                      out_last,
  output logic [CountBits-1:0]      live_count,
  output logic                      count_valid
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [RowBits-1:0] LastRow = RowBits'(Height - 1);

  function automatic logic [CountBits-1:0] popcount(input logic [Width-1:0] v);
    logic [CountBits-1:0] n;
    n = '0;
    for (int i = 0; i < Width; i++) begin
      n = n + CountBits'(v[i]);
    end
    return n;
  endfunction

  logic [1:0]                     fsm_q, fsm_d;
  logic [Height-1:0][Width-1:0]   snap_q, snap_d;
  logic [RowBits-1:0]             row_q, row_d;
  logic [CountBits-1:0]           acc_q, acc_d;
  logic [CountBits-1:0]           live_q, live_d;

  logic [Width-1:0]               row_data;
  logic [CountBits-1:0]           row_pop;
  logic                           accept;

  assign row_data = snap_q[row_q];
  assign row_pop  = popcount(row_data);
  assign accept   = (fsm_q == STREAM) && out_ready;

  always_comb begin
    fsm_d  = fsm_q;
    snap_d = snap_q;
    row_d  = row_q;
    acc_d  = acc_q;
    live_d = live_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          snap_d = state;
          row_d  = '0;
          acc_d  = '0;
          fsm_d  = STREAM;
        end
      end
      STREAM: begin
        if (accept) begin
          acc_d = acc_q + row_pop;
          if (row_q == LastRow) begin
            // Publish the count on the last beat's edge so that live_count is
            // already valid during the DONE cycle, alongside count_valid.
            live_d = acc_q + row_pop;
            fsm_d  = DONE;
          end else begin
            row_d = row_q + RowBits'(1);
          end
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= IDLE;
      snap_q <= '0;
      row_q  <= '0;
      acc_q  <= '0;
      live_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      snap_q <= snap_d;
      row_q  <= row_d;
      acc_q  <= acc_d;
      live_q <= live_d;
    end
  end

  // Beat outputs decode directly from registered state. They therefore hold
  // steady while stalled, and they clear as soon as the asynchronous reset asserts.
  // Outside STREAM the outputs are forced to zero so the sink never sees stale rows.
  assign busy        = (fsm_q != IDLE);
  assign out_valid   = (fsm_q == STREAM);
  assign out_data    = out_valid ? row_data : '0;
  assign out_row     = out_valid ? row_q : '0;
  assign out_first   = out_valid && (row_q == '0);
  assign out_last    = out_valid && (row_q == LastRow);
  assign count_valid = (fsm_q == DONE);
  assign live_count  = live_q;

endmodule

// File: tb/tb_binary_ca_frame_reader.sv
module tb_binary_ca_frame_reader;

  localparam int W = 8;
  localparam int H = 8;
  localparam logic [63:0] GLIDER = 64'h0000_0000_0704_0200;

  logic          clk;
  logic          rst;
  logic          start;
  logic [63:0]   state;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [2:0]    out_row;
  logic          out_first;
  logic          out_last;
  logic [6:0]    live_count;
  logic          count_valid;

  int checks = 0;
  int errors = 0;

  binary_ca_frame_reader #(.Width(W), .Height(H)) dut (
    .clk(clk), .rst(rst), .start(start), .state(state), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_first(out_first), .out_last(out_last),
    .live_count(live_count), .count_valid(count_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [6:0] exp_live);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_row"},   out_row, 0);
    chk({tag, "_first"}, out_first, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_cv"},    count_valid, 0);
    chk({tag, "_live"},  live_count, exp_live);
  endtask

  // Reference: a frame is the captured grid split into H rows of W bits,
  // delivered in order, with the count equal to the grid's population.
  // Called at a negedge. It returns at the negedge of the IDLE cycle after DONE.
  task automatic run_frame(input logic [63:0] grid, input int pct, input int exp_live,
                           input bit hold, input bit isolate);
    int t;
    int r;
    bit stalled;
    logic [7:0] pd;
    logic [2:0] pr;
    logic [7:0] exp_row;
    t = 0; r = 0; stalled = 0; pd = '0; pr = '0;
    state = grid;
    start = 1'b1;
    out_ready = ($urandom_range(99) < pct);
    while (r < H && t < 2000) begin
      @(negedge clk);
      t++;
      if (!hold && t == 1) start = 1'b0;
      if (isolate && t == 3) begin state = '1; start = 1'b1; end
      if (isolate && t == 4) start = 1'b0;
      chk("busy_stream", busy, 1);
      chk("count_valid_stream", count_valid, 0);
      if (t == 1) chk("valid_rise", out_valid, 1);
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_row", out_row, pr);
      end
      out_ready = ($urandom_range(99) < pct);
      stalled = 1'b0;
      if (out_valid) begin
        exp_row = grid[r*W +: W];
        chk("row_data", out_data, exp_row);
        chk("row_index", out_row, r);
        chk("row_first", out_first, (r == 0));
        chk("row_last", out_last, (r == H - 1));
        if (pct >= 100) chk("beat_time", t, r + 1);
        pd = out_data;
        pr = out_row;
        if (out_ready) r++;
        else stalled = 1'b1;
      end
    end
    if (r < H) begin
      chk("frame_timeout", r, H);
      return;
    end
    @(negedge clk);
    t++;
    chk("done_cv", count_valid, 1);
    chk("done_live", live_count, exp_live);
    chk("done_valid", out_valid, 0);
    chk("done_busy", busy, 1);
    if (pct >= 100) chk("done_time", t, H + 1);
    @(negedge clk);
    chk("idle_cv", count_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_live", live_count, exp_live);
  endtask

  typedef struct {
    logic [63:0] grid;
    int          ready_pct;
    int          exp_live;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] g;
    int pct;

    vecs[0] = '{GLIDER, 100, 5};
    vecs[1] = '{GLIDER, 50, 5};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 70, 64};
    vecs[3] = '{64'h0, 30, 0};
    vecs[4] = '{64'hAA55_AA55_AA55_AA55, 100, 32};
    vecs[5] = '{64'h8000_0000_0000_0001, 40, 2};

    // Reset with arbitrary inputs.
    rst = 1'b0;
    start = 1'b0;
    state = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      state = {$urandom, $urandom};
      out_ready = 1'($urandom);
      chk_idle_outputs("reset", 7'd0);
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset", 7'd0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].grid, vecs[i].ready_pct, vecs[i].exp_live, 1'b0, 1'b0);
    end

    // Isolation: grid changes and start pulses mid-frame must not disturb the frame.
    run_frame(GLIDER, 100, 5, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_second_frame_valid", out_valid, 0);
      chk("no_second_frame_busy", busy, 0);
    end
    run_frame(64'hFFFF_FFFF_FFFF_FFFF, 100, 64, 1'b0, 1'b0);

    // Mid-frame reset during the row 3 beat.
    state = GLIDER;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("pre_reset_row", out_row, 3);
    chk("pre_reset_live", live_count, 64);
    #1 rst = 1'b0;
    #1 chk_idle_outputs("midreset", 7'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_midreset", 7'd0);
    run_frame(GLIDER, 100, 5, 1'b0, 1'b0);

    // Held start on an all-zero grid gives back-to-back frames with one IDLE gap.
    run_frame(64'h0, 100, 0, 1'b1, 1'b0);
    run_frame(64'h0, 100, 0, 1'b1, 1'b0);
    run_frame(64'h0, 100, 0, 1'b1, 1'b0);
    start = 1'b0;
    @(negedge clk);
    chk("held_release_valid", out_valid, 0);

    // Randomized frames against the population model.
    for (int i = 0; i < 20; i++) begin
      g = {$urandom, $urandom};
      pct = $urandom_range(100, 20);
      run_frame(g, pct, $countones(g), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
